mux_scan_ctrl: RTL and testbench
================================

# mux_scan_ctrl

Sequencer that drives the 3-bit select of the 8:1 input mux and captures its 1-bit output into a parallel word. On `start` it walks the select through all eight inputs, waits a programmable dwell at each, samples the mux output, and presents the assembled 8-bit word on a valid/ready output port. Sits directly upstream (select) and downstream (data) of the 8:1 mux; consumers of the scanned word attach to the output handshake.

## Interface

Parameters:
- `DWELL_W`, default 4: width of the dwell count; per-step dwell range is 0..2^DWELL_W-1 extra cycles.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request a scan; honoured only in IDLE.
- `dwell`  in  DWELL_W  extra settle cycles per step; latched on start.
- `dir`  in  1  0 = scan 0→7, 1 = scan 7→0; latched on start.
- `sel_out`  out  3  drives the mux select `X`.
- `y_in`  in  1  the mux output `Y`.
- `busy`  out  1  high in SCAN and HOLD.
- `out_valid`  out  1  assembled word available.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  8  bit i = mux output sampled with select = i.

## Operation

- States: IDLE, SCAN, HOLD.
- IDLE: `sel_out`=0, `busy`=0, `out_valid`=0. `out_data` holds the last delivered word (0 after reset). `start`=1 → latch `dwell` and `dir`, set `sel_out` to 0 (dir=0) or 7 (dir=1), clear the step counter and the step index, and enter SCAN.
- SCAN: the step counter increments each cycle. When it equals the latched dwell:
  - write `y_in` into bit `sel_out` of the shadow word;
  - clear the counter;
  - step `sel_out` by +1 (dir=0) or −1 (dir=1).
- The step index counts 0..7 independently of `sel_out`. Termination on index 7 is independent of direction, so `sel_out` never wraps mid-scan.
- On the sample at step index 7, copy the shadow word to `out_data`, set `out_valid`=1, enter HOLD, and return `sel_out` to 0.
- HOLD: `out_data` is stable and `out_valid`=1 until `out_valid && out_ready` at an edge. Then `out_valid`=0 and the state goes to IDLE.
- `start` in SCAN or HOLD is ignored and not queued. This includes `start` in the handshake cycle.
- `dwell`, `dir` and `y_in` changes outside the sample cycle have no effect on the result.
- Reset, asserted at any state including mid-scan: state=IDLE, `sel_out`=0, `busy`=0, `out_valid`=0, `out_data`=0, shadow word=0, counters=0. A partial scan is discarded.

## Timing

- `start` sampled at edge k moves to SCAN with the first select at edge k.
- Each step occupies dwell+1 cycles. `y_in` for step n is sampled at edge k+(n+1)(dwell+1).
- `out_valid` rises at edge k+8(dwell+1):
  - dwell=0: 8 cycles after the start edge;
  - dwell=15: 128 cycles after the start edge.
- `out_ready` held high: `out_valid` is high for exactly 1 cycle.
- The earliest next `start` is accepted one edge after the handshake edge.
- All outputs are registered; there is no combinational path from `y_in` or `out_ready` to any output.

## Structure

- Shared package `mux_scan_pkg`:
  - state enum (IDLE, SCAN, HOLD);
  - `SEL_W`=3;
  - `N_IN`=8.
- One sub-module, `mux_scan_dwell_timer`:
  - DWELL_W-bit counter with load/clear;
  - `tick` output on count == latched dwell.
- The FSM, step index, shadow word and output register live in the top module.

## Test plan

- dwell=0, dir=0, mux inputs D0..D7 = 1,0,1,1,0,0,1,0:
  - `sel_out` sequence is 0,1,…,7 on consecutive cycles;
  - `out_valid` rises 8 cycles after start;
  - `out_data`=8'h4D.
- dwell=3, dir=1, same inputs:
  - `sel_out` is 7,6,…,0, each held 4 cycles;
  - `out_valid` rises at cycle 32;
  - `out_data`=8'h4D.
- Backpressure: `out_ready`=0 for 10 cycles after valid:
  - `out_valid` and `out_data` stay constant;
  - `start` pulses during that window are ignored;
  - raise `out_ready` → one transfer, then IDLE.
- Reset mid-scan: drive `rst_n`=0 for 1 cycle at step 4:
  - next cycle: state IDLE, `sel_out`=0, `out_data`=0, `out_valid`=0;
  - a new scan then returns the correct word.
- Input changes: change `dwell`/`dir` mid-scan and toggle `y_in` between sample edges. Only the values at sample edges affect `out_data`, and the timing follows the latched dwell.
- Back-to-back: start asserted continuously with `out_ready`=1. Scans repeat with exactly one IDLE cycle between the valid pulse and the next SCAN entry.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the 8:1 mux scan sequencer.
package mux_scan_pkg;

    localparam int SEL_W = 3;
    localparam int N_IN  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/mux_scan_dwell_timer.sv
// Per-step settle timer: latches the dwell on load and ticks once every dwell+1 running cycles.
module mux_scan_dwell_timer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               run,
    input  logic [DWELL_W-1:0] dwell,
    output logic               tick
);

    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] count;

    assign tick = run && (count == dwell_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dwell_q <= '0;
            count   <= '0;
        end else if (load) begin
            dwell_q <= dwell;
            count   <= '0;
        end else if (run) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Walks the 8:1 mux select through all inputs, samples Y at each step and
// delivers the assembled word on a valid/ready port.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               dir,
    output logic [SEL_W-1:0]   sel_out,
    input  logic               y_in,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_IN-1:0]    out_data,
    output state_e             state_dbg
);

    // Output handshake: a word transfers on any rising edge where out_valid
    // and out_ready are both high; out_valid and out_data never change while
    // out_valid is high and out_ready is low.

    state_e            state;
    logic              dir_q;
    logic [SEL_W-1:0]  step_idx;
    logic [N_IN-1:0]   shadow;
    logic [N_IN-1:0]   shadow_next;
    logic              launch;
    logic              tick;

    assign launch    = (state == ST_IDLE) && start;
    assign state_dbg = state;

    mux_scan_dwell_timer #(
        .DWELL_W(DWELL_W)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (launch),
        .run  (state == ST_SCAN),
        .dwell(dwell),
        .tick (tick)
    );

    always_comb begin
        shadow_next          = shadow;
        shadow_next[sel_out] = y_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            dir_q     <= 1'b0;
            sel_out   <= '0;
            step_idx  <= '0;
            shadow    <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_SCAN;
                        busy     <= 1'b1;
                        dir_q    <= dir;
                        sel_out  <= dir ? 3'd7 : 3'd0;
                        step_idx <= '0;
                        shadow   <= '0;
                    end
                end
                ST_SCAN: begin
                    if (tick) begin
                        shadow   <= shadow_next;
                        step_idx <= step_idx + 3'd1;
                        // Termination follows the step index, so the select never wraps.
                        if (step_idx == 3'd7) begin
                            out_data  <= shadow_next;
                            out_valid <= 1'b1;
                            sel_out   <= '0;
                            state     <= ST_HOLD;
                        end else begin
                            sel_out <= dir_q ? sel_out - 3'd1 : sel_out + 3'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: timing-based reference model, per-cycle compare, word scoreboard.
module tb_mux_scan_ctrl;
    import mux_scan_pkg::*;

    localparam int DW = 4;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] dwell = '0;
    logic          dir = 1'b0;
    logic          out_ready = 1'b0;
    logic          y_in;
    logic [2:0]    sel_out;
    logic          busy;
    logic          out_valid;
    logic [7:0]    out_data;
    state_e        state_dbg;

    always #5 clk = ~clk;

    // Mux model: D0..D7 are the bits of mux_word; glitch disturbs Y between samples.
    logic [7:0] mux_word = 8'h4D;
    logic       glitch = 1'b0;
    bit         glitch_en = 1'b0;
    bit         scramble_en = 1'b0;
    bit         chk_en = 1'b0;

    assign y_in = mux_word[sel_out] ^ glitch;

    mux_scan_ctrl #(.DWELL_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dwell    (dwell),
        .dir      (dir),
        .sel_out  (sel_out),
        .y_in     (y_in),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .state_dbg(state_dbg)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks elapsed cycles since the start edge; the select and sample
    // points follow directly from t / (dwell+1).
    localparam int M_IDLE = 0, M_SCAN = 1, M_HOLD = 2;
    int         m_state = M_IDLE;
    int         m_t = 0;
    int         m_d = 0;
    bit         m_dir = 1'b0;
    logic [7:0] m_word = '0;
    logic [7:0] m_data = '0;

    function automatic int m_sel();
        int step;
        if (m_state != M_SCAN) return 0;
        step = m_t / (m_d + 1);
        return m_dir ? 7 - step : step;
    endfunction

    always @(posedge clk) begin
        int s;
        if (!rst_n) begin
            m_state = M_IDLE;
            m_t     = 0;
            m_word  = '0;
            m_data  = '0;
            exp_q.delete();
        end else begin
            case (m_state)
                M_IDLE: if (start) begin
                    m_state = M_SCAN;
                    m_t     = 0;
                    m_d     = int'(dwell);
                    m_dir   = dir;
                    m_word  = '0;
                end
                M_SCAN: begin
                    s = m_sel();
                    m_t++;
                    if (m_t % (m_d + 1) == 0) begin
                        m_word[s] = mux_word[s] ^ glitch;
                        if (m_t == 8 * (m_d + 1)) begin
                            m_data  = m_word;
                            exp_q.push_back(m_word);
                            m_state = M_HOLD;
                        end
                    end
                end
                default: if (out_ready) m_state = M_IDLE;
            endcase
        end
    end

    // Disturb Y and the unlatched controls everywhere except at sample edges.
    always @(negedge clk) begin
        if (m_state == M_SCAN) begin
            if (glitch_en)
                glitch = ((m_t + 1) % (m_d + 1) == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            if (scramble_en) begin
                dwell = DW'($urandom_range(0, 15));
                dir   = 1'($urandom_range(0, 1));
            end
        end else begin
            glitch = 1'b0;
        end
    end

    // ---------------- compare + scoreboard ----------------
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("sel_out",   32'(sel_out),   32'(m_sel()));
            check("busy",      32'(busy),      32'(m_state != M_IDLE));
            check("out_valid", 32'(out_valid), 32'(m_state == M_HOLD));
            check("out_data",  32'(out_data),  32'(m_data));
        end
    end

    always @(posedge clk) begin
        logic [7:0] e;
        if (chk_en && rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sb_word", 32'(out_data), 32'(e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [2:0] sel_hist [0:255];

    task automatic run_scan(input int d, input bit dr, output int lat);
        int n = 0;
        @(negedge clk);
        start = 1'b1;
        dwell = DW'(d);
        dir   = dr;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (n < 256) sel_hist[n] = sel_out;
        end while (!out_valid && n < 300);
        lat = n - 1;
        if (!out_valid) check("valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic finish_xfer(input int wait_cycles);
        logic [7:0] held;
        held = out_data;
        for (int i = 0; i < wait_cycles; i++) begin
            @(negedge clk);
            start = ~start;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data",  32'(out_data),  32'(held));
        end
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b0;
        check("post_xfer_valid", 32'(out_valid), 32'd0);
        check("post_xfer_busy",  32'(busy),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        int n_hi;
        int first_hi;
        int second_hi;

        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        check("rst_sel",   32'(sel_out),   32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_data",  32'(out_data),  32'd0);

        // dwell=0, ascending
        run_scan(0, 1'b0, lat);
        check("lat_d0", 32'(lat), 32'd8);
        for (int i = 1; i <= 8; i++) check("sel_seq_d0", 32'(sel_hist[i]), 32'(i - 1));
        check("word_d0", 32'(out_data), 32'h4D);
        finish_xfer(0);

        // dwell=3, descending
        run_scan(3, 1'b1, lat);
        check("lat_d3", 32'(lat), 32'd32);
        for (int i = 1; i <= 32; i++) check("sel_seq_d3", 32'(sel_hist[i]), 32'(7 - (i - 1) / 4));
        check("word_d3", 32'(out_data), 32'h4D);
        finish_xfer(0);

        // backpressure with start pulses during the hold
        mux_word = 8'hB2;
        run_scan(1, 1'b0, lat);
        check("lat_bp", 32'(lat), 32'd16);
        check("word_bp", 32'(out_data), 32'hB2);
        finish_xfer(10);

        // reset during step 4
        @(negedge clk);
        start = 1'b1;
        dwell = DW'(1);
        dir   = 1'b0;
        repeat (9) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("mid_sel_step4", 32'(sel_out), 32'd4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
        check("mid_rst_sel",   32'(sel_out),   32'd0);
        check("mid_rst_data",  32'(out_data),  32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy",  32'(busy),      32'd0);
        mux_word = 8'h4D;
        run_scan(0, 1'b0, lat);
        check("word_after_rst", 32'(out_data), 32'h4D);
        finish_xfer(0);

        // dwell/dir/Y disturbed between sample edges
        mux_word    = 8'h96;
        glitch_en   = 1'b1;
        scramble_en = 1'b1;
        run_scan(2, 1'b1, lat);
        glitch_en   = 1'b0;
        scramble_en = 1'b0;
        check("lat_scramble", 32'(lat), 32'd24);
        check("word_scramble", 32'(out_data), 32'h96);
        finish_xfer(0);

        // back-to-back: valid every 8 + 2 cycles, one cycle wide
        mux_word = 8'h3C;
        @(negedge clk);
        start     = 1'b1;
        dwell     = '0;
        dir       = 1'b0;
        out_ready = 1'b1;
        n_hi      = 0;
        first_hi  = -1;
        second_hi = -1;
        for (int n = 1; n <= 35; n++) begin
            @(negedge clk);
            if (out_valid) begin
                n_hi++;
                if (first_hi < 0) first_hi = n;
                else if (second_hi < 0) second_hi = n;
            end
        end
        check("b2b_first",  32'(first_hi),  32'd9);
        check("b2b_second", 32'(second_hi), 32'd19);
        check("b2b_pulses", 32'(n_hi),      32'd3);
        start = 1'b0;
        repeat (10) @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        check("b2b_idle_busy", 32'(busy), 32'd0);

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
